// File: rtl/fp_div_mant_iter_if.sv
// Handshake/operand bundle between the FP divide front end and the mantissa divider.
interface fp_div_mant_iter_if #(
  parameter int MANT_W = 53,
  parameter int QUOT_W = MANT_W + 2
);
  logic              in_start;
  logic [MANT_W-1:0] in_dividend;
  logic [MANT_W-1:0] in_divisor;
  logic              out_busy;
  logic              out_done;
  logic [QUOT_W-1:0] out_quotient;
  logic              out_sticky;
  logic              out_div_by_zero;

  modport master (
    output in_start, in_dividend, in_divisor,
    input  out_busy, out_done, out_quotient, out_sticky, out_div_by_zero
  );

  modport slave (
    input  in_start, in_dividend, in_divisor,
    output out_busy, out_done, out_quotient, out_sticky, out_div_by_zero
  );
endinterface

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider, one quotient bit per clock (quotient + guard + round, sticky).
// Optional FP_DIV_EARLY_TERM_EN: finish as soon as the partial remainder reaches zero.
module fp_div_mant_iter #(
  parameter int MANT_W = 53,
  parameter int QUOT_W = MANT_W + 2,
  parameter int CNT_W  = 6
) (
  input  logic             in_clk,
  input  logic             in_rst,
  fp_div_mant_iter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [MANT_W:0]   rem;
  logic [MANT_W-1:0] div;
  logic [QUOT_W-1:0] q;
  logic [CNT_W-1:0]  cnt;
  logic [QUOT_W-1:0] quot;
  logic              sticky;
  logic              dbz;

  logic [MANT_W+1:0] step;
  logic [MANT_W:0]   rem_nxt;
  logic [QUOT_W-1:0] q_nxt;

  // Returns {quotient_bit, next_remainder}. rem < 2*div keeps the top bit of the
  // shifted value zero, so dropping it on the shift loses nothing.
  function automatic logic [MANT_W+1:0] restore_step(
    input logic [MANT_W:0]   r,
    input logic [MANT_W-1:0] d
  );
    logic [MANT_W:0] diff;
    if (r >= {1'b0, d}) begin
      diff = r - {1'b0, d};
      return {1'b1, diff[MANT_W-1:0], 1'b0};
    end
    return {1'b0, r[MANT_W-1:0], 1'b0};
  endfunction

  always_comb begin
    step    = restore_step(rem, div);
    rem_nxt = step[MANT_W:0];
    q_nxt   = {q[QUOT_W-2:0], step[MANT_W+1]};
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state  <= ST_IDLE;
      rem    <= '0;
      div    <= '0;
      q      <= '0;
      cnt    <= '0;
      quot   <= '0;
      sticky <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_start) begin
            if (bus.in_divisor != '0) begin
              rem    <= {1'b0, bus.in_dividend};
              div    <= bus.in_divisor;
              q      <= '0;
              cnt    <= CNT_W'(QUOT_W - 1);
              quot   <= '0;
              sticky <= 1'b0;
              dbz    <= 1'b0;
              state  <= ST_RUN;
            end else begin
              quot   <= '1;
              sticky <= 1'b0;
              dbz    <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          // Results are registered on the edge entering DONE so they are valid with out_done.
          if (cnt == '0) begin
            quot   <= q_nxt;
            sticky <= |rem_nxt;
            state  <= ST_DONE;
          end
`ifdef FP_DIV_EARLY_TERM_EN
          else if (rem_nxt == '0) begin
            quot   <= q_nxt << cnt;
            sticky <= 1'b0;
            state  <= ST_DONE;
          end
`endif
          else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_busy        = (state != ST_IDLE);
  assign bus.out_done        = (state == ST_DONE);
  assign bus.out_quotient    = quot;
  assign bus.out_sticky      = sticky;
  assign bus.out_div_by_zero = dbz;

endmodule

// File: tb/tb_fp_div_mant_iter.sv
// Randomized bench for fp_div_mant_iter against an arithmetic (long-division) reference.
module tb_fp_div_mant_iter;
  localparam int MANT_W = 53;
  localparam int QUOT_W = MANT_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_div_mant_iter_if #(.MANT_W(MANT_W), .QUOT_W(QUOT_W)) bus ();

  fp_div_mant_iter #(.MANT_W(MANT_W), .QUOT_W(QUOT_W), .CNT_W(6)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Quotient = floor(a * 2^(QUOT_W-1) / b), sticky = nonzero remainder.
  function automatic void model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                                output logic [QUOT_W-1:0] q, output logic s, output int lat);
    logic [127:0] num, den, quo;
    if (b == '0) begin
      q = '1; s = 1'b0; lat = 1;
      return;
    end
    num = {75'd0, a} << (QUOT_W - 1);
    den = {75'd0, b};
    quo = num / den;
    q   = quo[QUOT_W-1:0];
    s   = ((num % den) != 0);
    lat = QUOT_W + 1;
`ifdef FP_DIV_EARLY_TERM_EN
    // Exact after i+1 quotient bits once b divides a*2^i.
    for (int i = QUOT_W - 1; i >= 0; i--)
      if ((({75'd0, a} << i) % den) == 0) lat = i + 2;
`endif
  endfunction

  function automatic logic [MANT_W-1:0] rand_norm();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return {1'b1, t[MANT_W-2:0]};
  endfunction

  task automatic run_op(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                        input int inject_at, input string tag);
    logic [QUOT_W-1:0] eq;
    logic es;
    int   elat, lat;
    bit   busy_ok, seen;
    model(a, b, eq, es, elat);
    @(negedge clk);
    bus.in_start = 1'b1; bus.in_dividend = a; bus.in_divisor = b;
    @(posedge clk); #1;
    bus.in_start = 1'b0; bus.in_dividend = rand_norm(); bus.in_divisor = rand_norm();
    lat = 1; busy_ok = 1; seen = 0;
    while (lat < 100) begin
      if (bus.out_done) begin seen = 1; break; end
      if (!bus.out_busy) busy_ok = 0;
      if (lat == inject_at) begin
        bus.in_start = 1'b1; bus.in_dividend = rand_norm(); bus.in_divisor = rand_norm();
      end else begin
        bus.in_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_start = 1'b0;
    chk({tag, "_done_seen"}, 128'(seen), 128'(1));
    chk({tag, "_latency"}, 128'(lat), 128'(elat));
    chk({tag, "_quotient"}, 128'(bus.out_quotient), 128'(eq));
    chk({tag, "_sticky"}, 128'(bus.out_sticky), 128'(es));
    chk({tag, "_dbz"}, 128'(bus.out_div_by_zero), 128'(b == '0));
    chk({tag, "_busy_at_done"}, 128'(bus.out_busy), 128'(1));
    chk({tag, "_busy_held"}, 128'(busy_ok), 128'(1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 128'(bus.out_done), 128'(0));
    chk({tag, "_idle"}, 128'(bus.out_busy), 128'(0));
    chk({tag, "_q_hold"}, 128'(bus.out_quotient), 128'(eq));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 128'(bus.out_busy), 128'(0));
    chk({tag, "_done"}, 128'(bus.out_done), 128'(0));
    chk({tag, "_quot"}, 128'(bus.out_quotient), 128'(0));
    chk({tag, "_sticky"}, 128'(bus.out_sticky), 128'(0));
    chk({tag, "_dbz"}, 128'(bus.out_div_by_zero), 128'(0));
  endtask

  initial begin
    logic [MANT_W-1:0] a, b;
    bit saw_done;
    bus.in_start = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk); rst = 1'b0;

    run_op(53'h10_0000_0000_0000, 53'h10_0000_0000_0000, -1, "one_by_one");
    chk("one_by_one_const", 128'(bus.out_quotient), 128'h40_0000_0000_0000);
    run_op(53'h18_0000_0000_0000, 53'h10_0000_0000_0000, -1, "p5_by_one");
    chk("p5_by_one_const", 128'(bus.out_quotient), 128'h60_0000_0000_0000);
    run_op(53'h10_0000_0000_0000, 53'h18_0000_0000_0000, -1, "one_by_p5");
    chk("one_by_p5_const", 128'(bus.out_quotient), 128'h2A_AAAA_AAAA_AAAA);
    run_op(53'h10_0000_0000_0000, 53'h0, -1, "div_zero");
    chk("div_zero_const", 128'(bus.out_quotient), 128'h7F_FFFF_FFFF_FFFF);
    run_op(53'h10_0000_0000_0000, 53'h18_0000_0000_0000, 10, "start_busy");

    // Abort mid-run: reset sampled on the 20th edge after the start edge.
    @(negedge clk);
    bus.in_start = 1'b1; bus.in_dividend = 53'h1A_5A5A_5A5A_5A5A; bus.in_divisor = 53'h13_3333_3333_3333;
    @(posedge clk); #1;
    bus.in_start = 1'b0;
    saw_done = 0;
    repeat (19) begin
      @(posedge clk); #1;
      if (bus.out_done) saw_done = 1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_no_done", 128'(saw_done), 128'(0));
    chk_zero_outputs("abort");
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.out_done) saw_done = 1;
    end
    chk("abort_no_late_done", 128'(saw_done), 128'(0));
    run_op(53'h1F_0000_0000_0001, 53'h11_2345_6789_ABCD, -1, "after_abort");

    // Reset and start together: start dropped.
    @(negedge clk);
    rst = 1'b1; bus.in_start = 1'b1;
    bus.in_dividend = 53'h10_0000_0000_0000; bus.in_divisor = 53'h10_0000_0000_0000;
    @(negedge clk);
    rst = 1'b0; bus.in_start = 1'b0;
    @(posedge clk); #1;
    chk_zero_outputs("rst_start");

    for (int n = 0; n < 20; n++) begin
      a = rand_norm();
      case ($urandom_range(0, 3))
        0: b = 53'h10_0000_0000_0000;
        1: b = {rand_norm() >> 40, 40'd0} | 53'h10_0000_0000_0000;
        default: b = rand_norm();
      endcase
      if (n % 5 == 0) a = {a[MANT_W-1:30], 30'd0};
      run_op(a, b, (n % 7 == 3) ? 5 : -1, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
